uart_rx_buf_ctrl: RTL and testbench

Receive-side controller that sits between the UART receive state machine and the host register interface.
- Captures each received character (strobed by WE_RHR with RD[8:0]) into a first-word-fall-through receive FIFO.
- Serves host reads and tracks FIFO level.
- Flags overrun and error characters held in the FIFO.
- Runs a character timeout against CE_16x and generates a single masked interrupt.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo_ram.sv | 24 ++
 rtl/uart_rx_buf_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_rx_buf_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FIFO sizing, timeout FSM encoding,
// interrupt-enable bit positions and the receive-error bit position in RD.
package uart_pkg;

   localparam int DEPTH_LOG2 = 4;
   localparam int TO_LEN     = 640;
   localparam int RD_W       = 9;
   localparam int RD_ERR_BIT = 8;

   localparam int IE_THR = 0;
   localparam int IE_TO  = 1;
   localparam int IE_ERR = 2;

   typedef enum logic [1:0] {
      TO_Off   = 2'd0,
      TO_Count = 2'd1,
      TO_Flag  = 2'd2
   } to_state_e;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Receive FIFO storage: synchronous write, asynchronous read so the head entry
// falls through to RHR the cycle after it is written.
module uart_rx_fifo_ram
   import uart_pkg::*;
#(
   parameter int pDepthLog2 = DEPTH_LOG2
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [pDepthLog2-1:0] waddr_i,
   input  logic [RD_W-1:0]       wdata_i,
   input  logic [pDepthLog2-1:0] raddr_i,
   output logic [RD_W-1:0]       rdata_o
);

   logic [RD_W-1:0] mem_q [2**pDepthLog2];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer controller: FWFT receive FIFO with level/overrun/error
// tracking, character timeout against CE_16x, and one registered interrupt.
module uart_rx_buf_ctrl
   import uart_pkg::*;
#(
   parameter int pDepthLog2 = DEPTH_LOG2,
   parameter int pTOLen     = TO_LEN
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  CE_16x,
   input  logic [RD_W-1:0]       RD,
   input  logic                  WE_RHR,
   input  logic                  RxIdle,
   input  logic                  Clr,
   input  logic                  RE_RHR,
   output logic [RD_W-1:0]       RHR,
   output logic                  RxRdy,
   output logic                  Full,
   output logic [pDepthLog2:0]   Level,
   input  logic [pDepthLog2:0]   RxThr,
   output logic                  OvrErr,
   input  logic                  ClrOvr,
   output logic                  ErrInFIFO,
   output logic                  RxTO,
   input  logic [2:0]            IE,
   output logic                  IRQ
);

   localparam int PW = pDepthLog2;
   localparam int LW = pDepthLog2 + 1;
   localparam int CW = $clog2(pTOLen);
   localparam logic [LW-1:0] DEPTH    = LW'(2**pDepthLog2);
   localparam logic [CW-1:0] TO_LAST  = CW'(pTOLen - 1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [LW-1:0] err_cnt_q, err_cnt_d;
   logic          ovr_q, ovr_d;
   logic          irq_q, irq_d;
   to_state_e     to_state_q;
   logic [CW-1:0] to_cnt_q;

   logic wr_acc, rd_acc, ovr_set, thr_hit, any_acc;

   assign RxRdy     = (level_q != '0);
   assign Full      = (level_q == DEPTH);
   assign Level     = level_q;
   assign OvrErr    = ovr_q;
   assign ErrInFIFO = (err_cnt_q != '0);
   assign RxTO      = (to_state_q == TO_Flag);
   assign IRQ       = irq_q;

   // Clr outranks both strobes: the character is dropped and no overrun is recorded.
   assign wr_acc  = WE_RHR & (~Full | RE_RHR) & ~Clr;
   assign rd_acc  = RE_RHR & RxRdy & ~Clr;
   assign ovr_set = WE_RHR & Full & ~RE_RHR & ~Clr;
   assign any_acc = wr_acc | rd_acc;
   assign thr_hit = (RxThr != '0) & (level_q >= RxThr);

   uart_rx_fifo_ram #(.pDepthLog2(pDepthLog2)) u_ram (
      .clk_i   (Clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (RD),
      .raddr_i (rd_ptr_q),
      .rdata_o (RHR)
   );

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      err_cnt_d = err_cnt_q;
      if (Clr) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         err_cnt_d = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
         if (wr_acc & ~rd_acc) level_d = level_q + LW'(1);
         if (rd_acc & ~wr_acc) level_d = level_q - LW'(1);
         if ((wr_acc & RD[RD_ERR_BIT]) & ~(rd_acc & RHR[RD_ERR_BIT]))
            err_cnt_d = err_cnt_q + LW'(1);
         if ((rd_acc & RHR[RD_ERR_BIT]) & ~(wr_acc & RD[RD_ERR_BIT]))
            err_cnt_d = err_cnt_q - LW'(1);
      end
   end

   // Set wins over ClrOvr; Clr leaves the sticky flag alone.
   assign ovr_d = ovr_set | (ovr_q & ~ClrOvr);

   assign irq_d = (IE[IE_THR] & thr_hit) | (IE[IE_TO] & RxTO) |
                  (IE[IE_ERR] & (ovr_q | ErrInFIFO));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         err_cnt_q <= '0;
         ovr_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         err_cnt_q <= err_cnt_d;
         ovr_q     <= ovr_d;
         irq_q     <= irq_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst || Clr || (level_d == '0)) begin
         to_state_q <= TO_Off;
         to_cnt_q   <= '0;
      end else begin
         case (to_state_q)
            TO_Off: begin
               if (RxRdy) to_state_q <= TO_Count;
               to_cnt_q <= '0;
            end
            TO_Count: begin
               // Line activity or FIFO traffic restarts the quiet-time measurement.
               if (any_acc || !RxIdle) begin
                  to_cnt_q <= '0;
               end else if (CE_16x) begin
                  if (to_cnt_q == TO_LAST) begin
                     to_state_q <= TO_Flag;
                     to_cnt_q   <= '0;
                  end else begin
                     to_cnt_q <= to_cnt_q + CW'(1);
                  end
               end
            end
            TO_Flag: begin
               if (any_acc) begin
                  to_state_q <= TO_Count;
                  to_cnt_q   <= '0;
               end
            end
            default: begin
               to_state_q <= TO_Off;
               to_cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Self-checking bench for uart_rx_buf_ctrl: directed scenarios plus a randomized
// run against a queue-based model of the receive FIFO and its flags.
module tb_uart_rx_buf_ctrl;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       CE_16x = 1'b0;
   logic [8:0] RD = '0;
   logic       WE_RHR = 1'b0;
   logic       RxIdle = 1'b1;
   logic       Clr = 1'b0;
   logic       RE_RHR = 1'b0;
   logic [8:0] RHR;
   logic       RxRdy, Full, OvrErr, ErrInFIFO, RxTO, IRQ;
   logic [4:0] Level;
   logic [4:0] RxThr = '0;
   logic       ClrOvr = 1'b0;
   logic [2:0] IE = '0;

   int checks = 0;
   int failures = 0;

   logic [8:0] q[$];
   bit m_ovr, m_irq, m_rxto;

   always #5 Clk = ~Clk;

   uart_rx_buf_ctrl dut (
      .Clk(Clk), .Rst(Rst), .CE_16x(CE_16x), .RD(RD), .WE_RHR(WE_RHR),
      .RxIdle(RxIdle), .Clr(Clr), .RE_RHR(RE_RHR), .RHR(RHR), .RxRdy(RxRdy),
      .Full(Full), .Level(Level), .RxThr(RxThr), .OvrErr(OvrErr), .ClrOvr(ClrOvr),
      .ErrInFIFO(ErrInFIFO), .RxTO(RxTO), .IE(IE), .IRQ(IRQ)
   );

   function automatic bit m_err();
      foreach (q[i]) if (q[i][8]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock with the given strobes; the model advances from pre-edge state.
   task automatic step(input bit we, input logic [8:0] d, input bit re,
                       input bit clr, input bit co);
      int  lvl;
      bit  full, thr, irq_n, racc, wacc;
      lvl   = q.size();
      full  = (lvl == 16);
      thr   = (RxThr != 0) && (lvl >= int'(RxThr));
      irq_n = (IE[0] && thr) || (IE[1] && m_rxto) || (IE[2] && (m_ovr || m_err()));
      WE_RHR = we; RD = d; RE_RHR = re; Clr = clr; ClrOvr = co;
      @(posedge Clk); #1;
      m_irq = irq_n;
      if (!clr && we && full && !re) m_ovr = 1'b1;
      else if (co) m_ovr = 1'b0;
      if (clr) begin
         q.delete();
         m_rxto = 1'b0;
      end else begin
         racc = re && (lvl > 0);
         wacc = we && (!full || re);
         if (racc) void'(q.pop_front());
         if (wacc) q.push_back(d);
         if (racc || wacc || q.size() == 0) m_rxto = 1'b0;
      end
      WE_RHR = 1'b0; RE_RHR = 1'b0; Clr = 1'b0; ClrOvr = 1'b0;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      q.delete();
      m_ovr = 0; m_irq = 0; m_rxto = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({Level, RxRdy, Full, OvrErr, ErrInFIFO, RxTO, IRQ} !== 11'b0) begin
         failures++;
         $display("FAIL reset_state: Level=%0d RxRdy=%b Full=%b OvrErr=%b ErrInFIFO=%b RxTO=%b IRQ=%b, required all 0",
                  Level, RxRdy, Full, OvrErr, ErrInFIFO, RxTO, IRQ);
      end
   endtask

   task automatic test_fifo_order();
      logic [8:0] exp_d;
      step(1, 9'h041, 0, 0, 0);
      step(1, 9'h042, 0, 0, 0);
      step(1, 9'h043, 0, 0, 0);
      checks++;
      if (Level !== 5'd3) begin
         failures++; $display("FAIL order_level3: got %0d need 3", Level);
      end
      for (int i = 0; i < 3; i++) begin
         exp_d = 9'h041 + 9'(i);
         checks++;
         if (RHR !== exp_d) begin
            failures++; $display("FAIL order_rhr%0d: got %h need %h", i, RHR, exp_d);
         end
         step(0, 9'h0, 1, 0, 0);
         checks++;
         if (Level !== 5'(2 - i)) begin
            failures++; $display("FAIL order_level: got %0d need %0d", Level, 2 - i);
         end
      end
      checks++;
      if (RxRdy !== 1'b0) begin
         failures++; $display("FAIL order_rxrdy: got %b need 0", RxRdy);
      end
   endtask

   task automatic test_overrun();
      logic [8:0] first;
      first = 9'($urandom_range(0, 255));
      step(1, first, 0, 0, 0);
      for (int i = 1; i < 16; i++) step(1, 9'($urandom_range(0, 255)), 0, 0, 0);
      checks++;
      if (Full !== 1'b1 || Level !== 5'd16 || OvrErr !== 1'b0) begin
         failures++;
         $display("FAIL ovr_full: Full=%b Level=%0d OvrErr=%b need 1/16/0", Full, Level, OvrErr);
      end
      step(1, 9'h1FF, 0, 0, 0);
      checks++;
      if (OvrErr !== 1'b1 || Level !== 5'd16 || RHR !== first) begin
         failures++;
         $display("FAIL ovr_drop: OvrErr=%b Level=%0d RHR=%h need 1/16/%h", OvrErr, Level, RHR, first);
      end
      step(1, 9'h1FE, 0, 0, 1);
      checks++;
      if (OvrErr !== 1'b1) begin
         failures++; $display("FAIL ovr_set_beats_clr: got %b need 1", OvrErr);
      end
      step(0, 9'h0, 0, 0, 1);
      checks++;
      if (OvrErr !== 1'b0) begin
         failures++; $display("FAIL ovr_clear: got %b need 0", OvrErr);
      end
   endtask

   task automatic test_full_rw();
      logic [8:0] last;
      step(1, 9'h0AA, 1, 0, 0);
      checks++;
      if (OvrErr !== 1'b0 || Level !== 5'd16) begin
         failures++;
         $display("FAIL full_rw: OvrErr=%b Level=%0d need 0/16", OvrErr, Level);
      end
      last = 9'h0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (RHR !== q[0]) begin
            failures++; $display("FAIL full_drain%0d: got %h need %h", i, RHR, q[0]);
         end
         last = RHR;
         step(0, 9'h0, 1, 0, 0);
      end
      checks++;
      if (last !== 9'h0AA || RxRdy !== 1'b0) begin
         failures++; $display("FAIL full_last: got %h RxRdy=%b need 0aa/0", last, RxRdy);
      end
   endtask

   task automatic test_err_irq();
      IE = 3'b100;
      step(1, 9'h155, 0, 0, 0);
      checks++;
      if (ErrInFIFO !== 1'b1 || IRQ !== 1'b0) begin
         failures++; $display("FAIL err_set: ErrInFIFO=%b IRQ=%b need 1/0", ErrInFIFO, IRQ);
      end
      step(1, 9'h041, 0, 0, 0);
      checks++;
      if (IRQ !== 1'b1) begin
         failures++; $display("FAIL err_irq_rise: got %b need 1", IRQ);
      end
      step(0, 9'h0, 1, 0, 0);
      checks++;
      if (ErrInFIFO !== 1'b0 || IRQ !== 1'b1 || RHR !== 9'h041) begin
         failures++;
         $display("FAIL err_clear: ErrInFIFO=%b IRQ=%b RHR=%h need 0/1/041", ErrInFIFO, IRQ, RHR);
      end
      step(0, 9'h0, 0, 0, 0);
      checks++;
      if (IRQ !== 1'b0) begin
         failures++; $display("FAIL err_irq_fall: got %b need 0", IRQ);
      end
      step(0, 9'h0, 1, 0, 0);
      IE = 3'b000;
   endtask

   task automatic run_ticks(input int n, input int idle_low_at, input int chk_a,
                            input int chk_b, input int chk_c);
      for (int k = 1; k <= n; k++) begin
         CE_16x = 1'b1;
         RxIdle = (k == idle_low_at) ? 1'b0 : 1'b1;
         step(0, 9'h0, 0, 0, 0);
         CE_16x = 1'b0;
         RxIdle = 1'b1;
         if (k == chk_a || k == chk_b || k == chk_c) begin
            checks++;
            if (RxTO !== (k == n)) begin
               failures++; $display("FAIL timeout_tick%0d: got %b need %b", k, RxTO, k == n);
            end
         end
         step(0, 9'h0, 0, 0, 0);
      end
   endtask

   task automatic test_timeout();
      step(1, 9'h061, 0, 0, 0);
      step(0, 9'h0, 0, 0, 0);
      run_ticks(640, 0, 639, 640, 0);
      step(0, 9'h0, 1, 0, 0);
      checks++;
      if (RxTO !== 1'b0) begin
         failures++; $display("FAIL timeout_read_clear: got %b need 0", RxTO);
      end
      step(1, 9'h062, 0, 0, 0);
      step(0, 9'h0, 0, 0, 0);
      run_ticks(940, 300, 640, 939, 940);
      m_rxto = 1'b1;
      IE = 3'b010;
      step(0, 9'h0, 0, 0, 0);
      checks++;
      if (IRQ !== 1'b1) begin
         failures++; $display("FAIL timeout_irq: got %b need 1", IRQ);
      end
      step(0, 9'h0, 1, 0, 0);
      checks++;
      if (RxTO !== 1'b0) begin
         failures++; $display("FAIL timeout_read_clear2: got %b need 0", RxTO);
      end
      IE = 3'b000;
      step(0, 9'h0, 0, 0, 0);
   endtask

   task automatic test_threshold();
      bit ovr_before;
      RxThr = 5'd4;
      IE = 3'b001;
      for (int i = 0; i < 4; i++) step(1, 9'h030 + 9'(i), 0, 0, 0);
      checks++;
      if (Level !== 5'd4 || IRQ !== 1'b0) begin
         failures++; $display("FAIL thr_level: Level=%0d IRQ=%b need 4/0", Level, IRQ);
      end
      ovr_before = m_ovr;
      step(1, 9'h0FF, 0, 0, 0);
      checks++;
      if (IRQ !== 1'b1) begin
         failures++; $display("FAIL thr_irq_rise: got %b need 1", IRQ);
      end
      step(1, 9'h0EE, 0, 1, 0);
      checks++;
      if (Level !== 5'd0 || OvrErr !== ovr_before) begin
         failures++;
         $display("FAIL thr_clr: Level=%0d OvrErr=%b need 0/%b", Level, OvrErr, ovr_before);
      end
      step(0, 9'h0, 0, 0, 0);
      checks++;
      if (IRQ !== 1'b0) begin
         failures++; $display("FAIL thr_irq_fall: got %b need 0", IRQ);
      end
      RxThr = 5'd0;
      IE = 3'b000;
   endtask

   task automatic test_random();
      bit we, re, clr, co;
      step(0, 9'h0, 0, 1, 1);
      IE = 3'b111;
      for (int n = 0; n < 600; n++) begin
         if (n % 100 == 0) RxThr = 5'($urandom_range(0, 16));
         we  = ($urandom_range(0, 99) < 60);
         re  = ($urandom_range(0, 99) < 35);
         clr = ($urandom_range(0, 59) == 0);
         co  = ($urandom_range(0, 14) == 0);
         step(we, 9'($urandom), re, clr, co);
         checks++;
         if (Level !== 5'(q.size()) || RxRdy !== (q.size() != 0) ||
             Full !== (q.size() == 16) || OvrErr !== m_ovr ||
             ErrInFIFO !== m_err() || IRQ !== m_irq ||
             (q.size() != 0 && RHR !== q[0])) begin
            failures++;
            $display("FAIL random%0d: Level=%0d RxRdy=%b Full=%b Ovr=%b Err=%b IRQ=%b RHR=%h need %0d/%b/%b/%b/%b/%b/%h",
                     n, Level, RxRdy, Full, OvrErr, ErrInFIFO, IRQ, RHR,
                     q.size(), q.size() != 0, q.size() == 16, m_ovr, m_err(), m_irq,
                     (q.size() != 0) ? q[0] : 9'h0);
         end
      end
      IE = 3'b000;
   endtask

   task automatic test_reset_mid();
      step(1, 9'h1A5, 0, 0, 0);
      step(1, 9'h0A6, 0, 0, 0);
      do_reset();
      checks++;
      if (Level !== 5'd0 || RxRdy !== 1'b0 || ErrInFIFO !== 1'b0 || OvrErr !== 1'b0 || IRQ !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: Level=%0d RxRdy=%b Err=%b Ovr=%b IRQ=%b need all 0",
                  Level, RxRdy, ErrInFIFO, OvrErr, IRQ);
      end
      step(1, 9'h123, 0, 0, 0);
      checks++;
      if (RHR !== 9'h123 || Level !== 5'd1) begin
         failures++; $display("FAIL reset_mid_fresh: RHR=%h Level=%0d need 123/1", RHR, Level);
      end
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_overrun();
      test_full_rw();
      test_err_irq();
      test_timeout();
      test_threshold();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
